// File: rtl/io_pkg.sv
// io_pkg: shared constants and the read-address decode helper for the
// memory-mapped input port (ioread_mux) and its consumer, memorio.
//
// Contents:
//   - channel-count and width limits for the input port
//   - IO_STATUS_SEL: address of the status word, equal to the channel count
//   - io_sel_e / io_decode(): classify a read address as channel, status or unused
package io_pkg;

  // Channel-count and width limits.
  localparam int IO_MIN_CH      = 1;
  localparam int IO_MAX_CH      = 8;
  localparam int IO_MIN_DATA_W  = 1;
  localparam int IO_MAX_DATA_W  = 32;

  // Default channel count; the status word sits right after the last channel.
  localparam int IO_DEFAULT_CH  = 4;
  localparam int IO_STATUS_SEL  = IO_DEFAULT_CH;

  // Read-address classes shared with memorio.
  typedef enum logic [1:0] {
    SEL_CHANNEL = 2'd0,
    SEL_STATUS  = 2'd1,
    SEL_NONE    = 2'd2
  } io_sel_e;

  // Addresses below num_ch pick a channel, num_ch picks the status word,
  // anything above reads as zero.
  function automatic io_sel_e io_decode(input int unsigned addr,
                                        input int unsigned num_ch);
    if (addr < num_ch)
      return SEL_CHANNEL;
    else if (addr == num_ch)
      return SEL_STATUS;
    else
      return SEL_NONE;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one input channel of the I/O read port.
//
// A two-flop synchroniser feeds a whole-word debouncer. The synchronised
// word must differ from the accepted (stable) word for DEBOUNCE_CYC
// consecutive cycles before it is taken; any cycle where it matches the
// stable word again restarts the count.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   din      in   raw asynchronous channel input
//   stable   out  currently accepted (debounced) value
//   accept   out  high in the cycle whose rising edge loads a new stable value
module io_debounce #(
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] stable,
  output logic              accept
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [DATA_W-1:0] sync1_reg;
  logic [DATA_W-1:0] sync2_reg;
  logic [DATA_W-1:0] stable_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              differ;

  assign differ = (sync2_reg != stable_reg);
  // Combinational so the top can set the change flag on the same edge that
  // loads stable_reg.
  assign accept = differ && (cnt_reg == CNT_LAST);
  assign stable = stable_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ioread_mux.sv
// ioread_mux: synchronised, debounced multi-channel input port on the CPU's
// memory-mapped I/O read path.
//
// Each channel runs through io_debounce. On a controller read (ior) the
// selected channel's stable value, or the status word of sticky change
// flags, is registered into ioread_data together with a one-cycle
// ioread_valid pulse. Reading a channel clears its flag unless the channel
// accepts a new value on the same edge.
//
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   ior           in   read strobe from the controller
//   io_addr       in   0..NUM_CH-1 channel, NUM_CH status, above reads zero
//   io_in         in   raw inputs, channel i at [i*DATA_W +: DATA_W]
//   ioread_data   out  registered, zero-extended read data
//   ioread_valid  out  one-cycle pulse when ioread_data was loaded
//   io_new        out  sticky per-channel change flags
module ioread_mux
  import io_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 8,
  parameter int OUT_W        = 32,
  parameter int ADDR_W       = 3,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ior,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic [NUM_CH*DATA_W-1:0] io_in,
  output logic [OUT_W-1:0]         ioread_data,
  output logic                     ioread_valid,
  output logic [NUM_CH-1:0]        io_new
);

  logic [DATA_W-1:0] stable_arr [NUM_CH];
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] clear_mask;
  logic [OUT_W-1:0]  read_word;
  io_sel_e           sel;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      io_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (io_in[gi*DATA_W +: DATA_W]),
        .stable  (stable_arr[gi]),
        .accept  (accept[gi])
      );
    end
  endgenerate

  // Read mux and flag-clear decode. Uses the pre-edge stable values, so a
  // read on the edge that accepts new data still returns the old word.
  always_comb begin
    sel        = io_decode(32'(io_addr), NUM_CH);
    read_word  = '0;
    clear_mask = '0;
    case (sel)
      SEL_CHANNEL: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (io_addr == ADDR_W'(i)) begin
            read_word     = OUT_W'(stable_arr[i]);
            clear_mask[i] = ior;
          end
        end
      end
      SEL_STATUS: read_word = OUT_W'(io_new);
      default:    read_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ioread_data  <= '0;
      ioread_valid <= 1'b0;
      io_new       <= '0;
    end else begin
      ioread_valid <= ior;
      if (ior)
        ioread_data <= read_word;
      // Acceptance wins over a same-edge read clear.
      io_new <= (io_new & ~clear_mask) | accept;
    end
  end

endmodule

// File: tb/tb_ioread_mux.sv
module tb_ioread_mux;

  localparam int NCH = 4;
  localparam int DB  = 4;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        ior     = 1'b0;
  logic [2:0]  io_addr = 3'd0;
  logic [31:0] io_in   = 32'h0;
  logic [31:0] ioread_data;
  logic        ioread_valid;
  logic [3:0]  io_new;

  ioread_mux #(
    .NUM_CH       (NCH),
    .DATA_W       (8),
    .OUT_W        (32),
    .ADDR_W       (3),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ior          (ior),
    .io_addr      (io_addr),
    .io_in        (io_in),
    .ioread_data  (ioread_data),
    .ioread_valid (ioread_valid),
    .io_new       (io_new)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs reach the debouncer two edges late (a two-entry delay line).
  // Each channel remembers how many consecutive synchronised samples have
  // disagreed with its accepted value; DB of them in a row adopt the new one.
  logic [7:0]  m_stable [NCH];
  int          m_run    [NCH];
  logic [3:0]  m_new;
  logic [31:0] m_data;
  logic        m_valid;
  logic [31:0] m_dl [$];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_stable[c] = 8'h0;
      m_run[c]    = 0;
    end
    m_new   = 4'h0;
    m_data  = 32'h0;
    m_valid = 1'b0;
    m_dl.delete();
    m_dl.push_back(32'h0);
    m_dl.push_back(32'h0);
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_step();
    logic [31:0] s2;
    logic [3:0]  clr;
    logic [3:0]  acc;
    logic [7:0]  v;
    s2  = m_dl[0];
    clr = 4'h0;
    acc = 4'h0;
    m_valid = ior;
    if (ior) begin
      if (io_addr < 3'(NCH)) begin
        m_data = {24'h0, m_stable[io_addr]};
        clr[io_addr[1:0]] = 1'b1;
      end else if (io_addr == 3'(NCH)) begin
        m_data = {28'h0, m_new};
      end else begin
        m_data = 32'h0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      v = s2[c*8 +: 8];
      if (v == m_stable[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DB) begin
          m_stable[c] = v;
          acc[c]      = 1'b1;
          m_run[c]    = 0;
        end
      end
    end
    m_new = (m_new & ~clr) | acc;
    void'(m_dl.pop_front());
    m_dl.push_back(io_in);
  endtask

  // One clock: apply inputs, step the model, sample #1 after the edge.
  task automatic tick(input logic [31:0] din, input logic rd, input logic [2:0] addr);
    io_in   = din;
    ior     = rd;
    io_addr = addr;
    model_step();
    @(posedge clock);
    #1;
    check("model_data",  ioread_data,  m_data);
    check("model_valid", ioread_valid, m_valid);
    check("model_new",   io_new,       m_new);
    $display("tick in=%08h ior=%0b addr=%0d -> data=%08h valid=%0b new=%h",
             din, rd, addr, ioread_data, ioread_valid, io_new);
  endtask

  // Called at posedge+1; holds reset over a few edges, releases between edges.
  task automatic do_reset(input logic [31:0] din);
    reset_n = 1'b0;
    io_in   = din;
    ior     = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_data",  ioread_data,  32'h0);
    check("reset_valid", ioread_valid, 32'h0);
    check("reset_new",   io_new,       32'h0);
    #3 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [3:0]  exp_new;
  } vec_t;

  vec_t vecs [15];

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tick(vecs[i].din, vecs[i].rd, vecs[i].addr);
      check($sformatf("vec%0d_data", i),  ioread_data,  vecs[i].exp_data);
      check($sformatf("vec%0d_valid", i), ioread_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_new", i),   io_new,       vecs[i].exp_new);
    end
  endtask

  logic [31:0] cur;
  logic [31:0] din;

  initial begin
    // Reset released with all inputs high, continuous channel-0 reads.
    for (int i = 0; i < 5; i++)
      vecs[i] = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h0, 1'b1, 4'h0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h00, 1'b1, 4'hF};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'hFF, 1'b1, 4'hE};
    vecs[7] = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'hFF, 1'b1, 4'hE};
    // After an async reset mid-count: full latency again from zero.
    for (int i = 8; i < 13; i++)
      vecs[i] = '{32'h3CA5_0177, 1'b1, 3'd0, 32'h0, 1'b1, 4'h0};
    vecs[13] = '{32'h3CA5_0177, 1'b1, 3'd0, 32'h00, 1'b1, 4'hF};
    vecs[14] = '{32'h3CA5_0177, 1'b1, 3'd0, 32'h77, 1'b1, 4'hE};

    model_reset();
    @(posedge clock);
    #1;
    do_reset(32'hFFFF_FFFF);
    run_vecs(0, 7);

    // Bounce: held for DB-1 synchronised cycles only, then back to 0.
    do_reset(32'h0);
    repeat (3) tick(32'h0000_0100, 1'b0, 3'd0);
    repeat (6) tick(32'h0, 1'b0, 3'd0);
    check("bounce_new", io_new, 32'h0);
    tick(32'h0, 1'b1, 3'd1);
    check("bounce_ch1", ioread_data, 32'h0);
    repeat (8) tick(32'h0000_0100, 1'b0, 3'd0);
    check("hold_new", io_new, 32'h2);
    tick(32'h0000_0100, 1'b1, 3'd1);
    check("hold_ch1", ioread_data, 32'h01);
    check("hold_clear", io_new, 32'h0);

    // Flags: ch2 change shows in status, channel read clears it.
    din = 32'h00A5_0100;
    repeat (8) tick(din, 1'b0, 3'd0);
    tick(din, 1'b1, 3'd4);
    check("status_ch2", ioread_data, 32'h4);
    tick(din, 1'b1, 3'd2);
    check("read_ch2", ioread_data, 32'hA5);
    check("read_ch2_valid", ioread_valid, 32'h1);
    check("read_ch2_clear", io_new, 32'h0);
    tick(din, 1'b0, 3'd0);
    check("valid_drop", ioread_valid, 32'h0);
    tick(din, 1'b1, 3'd4);
    check("status_clear", ioread_data, 32'h0);

    // Same-edge read of ch3 and acceptance of 0x3C.
    din = 32'h3CA5_0100;
    repeat (5) tick(din, 1'b0, 3'd0);
    tick(din, 1'b1, 3'd3);
    check("same_edge_old", ioread_data, 32'h0);
    check("same_edge_flag", io_new, 32'h8);

    // Addressing and hold.
    tick(din, 1'b1, 3'd2);
    check("pre_hold", ioread_data, 32'hA5);
    for (int i = 0; i < 5; i++) begin
      tick(din, 1'b0, 3'd5);
      check($sformatf("hold%0d_data", i), ioread_data, 32'hA5);
      check($sformatf("hold%0d_valid", i), ioread_valid, 32'h0);
    end
    tick(din, 1'b1, 3'd7);
    check("addr7_data", ioread_data, 32'h0);
    check("addr7_valid", ioread_valid, 32'h1);
    check("addr7_flags", io_new, 32'h8);
    tick(din, 1'b1, 3'd4);
    check("status_ch3", ioread_data, 32'h8);
    tick(din, 1'b1, 3'd3);
    check("read_ch3", ioread_data, 32'h3C);
    check("read_ch3_clear", io_new, 32'h0);

    // Async reset with ch0 counter at 2.
    din = 32'h3CA5_0177;
    repeat (3) tick(din, 1'b0, 3'd0);
    tick(din, 1'b1, 3'd2);
    check("pre_async", ioread_data, 32'hA5);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_data",  ioread_data,  32'h0);
    check("async_valid", ioread_valid, 32'h0);
    check("async_new",   io_new,       32'h0);
    @(posedge clock);
    #4 reset_n = 1'b1;
    run_vecs(8, 14);

    // Randomised traffic against the model.
    cur = din;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < NCH; c++) begin
          case ($urandom_range(0, 5))
            0: cur[c*8 +: 8] = 8'h00;
            1: cur[c*8 +: 8] = 8'h5A;
            2: cur[c*8 +: 8] = 8'($urandom);
            3: cur[c*8 +: 8] = cur[c*8 +: 8] ^ 8'h01;
            default: ;
          endcase
        end
      end
      tick(cur, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
